// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: redirect input, inst_rom CPU port and the IF/ID handshake.
// The master side is the fetch stage; the slave side is everything around it.
`timescale 1ns/1ps

interface inst_fetch_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              rom_read_enable;
   logic [ADDR_W-1:0] rom_address;
   logic [DATA_W-1:0] rom_inst;
   logic              id_valid;
   logic [ADDR_W-1:0] id_pc;
   logic [DATA_W-1:0] id_inst;
   logic              id_ready;

   modport master (
      input  redirect_valid, redirect_pc, rom_inst, id_ready,
      output rom_read_enable, rom_address, id_valid, id_pc, id_inst
   );

   modport slave (
      output redirect_valid, redirect_pc, rom_inst, id_ready,
      input  rom_read_enable, rom_address, id_valid, id_pc, id_inst
   );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, 1-cycle inst_rom requests, IF/ID output
// register with a one-entry skid buffer for the response in flight during a stall.
`timescale 1ns/1ps

module inst_fetch #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                PC_STEP  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   inst_fetch_if.master bus
);

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] inst;
   } entry_t;

   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] inflight_pc;
   logic              inflight;
   logic              squash;
   logic              skid_valid;
   entry_t            skid_q;
   logic              id_valid_q;
   entry_t            id_q;

   logic              issue;
   logic              loadable;
   logic              landing;
   logic              land_direct;
   logic [ADDR_W-1:0] redirect_target;

   // NOTE: every signal is assigned on every pass through always_comb, so no latch is inferred.
   always_comb begin
      loadable        = !id_valid_q || bus.id_ready;
      landing         = inflight && !squash;
      land_direct     = landing && loadable && !skid_valid;
      redirect_target = bus.redirect_pc & ~ADDR_W'(3);
      issue           = rst_n && !bus.redirect_valid && !skid_valid &&
                        (!inflight || !id_valid_q || bus.id_ready);
   end

   assign bus.rom_read_enable = issue;
   assign bus.rom_address     = pc_q;
   assign bus.id_valid        = id_valid_q;
   assign bus.id_pc           = id_q.pc;
   assign bus.id_inst         = id_q.inst;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         inflight   <= 1'b0;
         squash     <= 1'b0;
         skid_valid <= 1'b0;
         id_valid_q <= 1'b0;
         id_q       <= '0;
      end else if (bus.redirect_valid) begin
         // Redirect wins: drop output, skid and whatever response is arriving.
         pc_q       <= redirect_target;
         inflight   <= 1'b0;
         squash     <= 1'b1;
         skid_valid <= 1'b0;
         id_valid_q <= 1'b0;
      end else begin
         if (issue) begin
            pc_q     <= pc_q + ADDR_W'(PC_STEP);
            inflight <= 1'b1;
            squash   <= 1'b0;
         end else begin
            inflight <= 1'b0;
         end

         if (land_direct) begin
            id_q       <= '{pc: inflight_pc, inst: bus.rom_inst};
            id_valid_q <= 1'b1;
         end else if (landing) begin
            skid_valid <= 1'b1;
         end else if (skid_valid && loadable) begin
            id_q       <= skid_q;
            id_valid_q <= 1'b1;
            skid_valid <= 1'b0;
         end else if (id_valid_q && bus.id_ready) begin
            id_valid_q <= 1'b0;
         end
      end
   end

   // NOTE: pure data holding registers are left unreset; their valid flags above gate every use.
   always_ff @(posedge clk) begin
      if (issue) begin
         inflight_pc <= pc_q;
      end
      if (rst_n && !bus.redirect_valid && landing && !land_direct) begin
         skid_q <= '{pc: inflight_pc, inst: bus.rom_inst};
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: behavioural inst_rom plus a scoreboard of the
// expected fetch order, popped on every accepted IF/ID transfer.
`timescale 1ns/1ps

module tb_inst_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   exp_t exp_q[$];

   inst_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   inst_fetch #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .RESET_PC(RESET_PC),
      .PC_STEP (4)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: rom_word = 32'h0050_0093;
         32'h0000_0004: rom_word = 32'h00A0_0113;
         32'h0000_0008: rom_word = 32'h0020_81B3;
         default:       rom_word = a ^ 32'h1357_9BDF;
      endcase
   endfunction

   // ROM data is only meaningful the cycle after a request; garbage otherwise.
   always @(posedge clk) begin
      if (bus.rom_read_enable) bus.rom_inst <= rom_word(bus.rom_address);
      else                     bus.rom_inst <= 32'hDEAD_BEEF;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input logic [31:0] start);
      exp_q.delete();
      for (int k = 0; k < 64; k++) begin
         logic [31:0] a;
         a = start + 32'(k * 4);
         exp_q.push_back('{pc: a, inst: rom_word(a)});
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.id_valid && bus.id_ready) begin
         if (exp_q.size() == 0) begin
            check("xfer_expected", 64'(exp_q.size()), 64'(1));
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("xfer_pc", bus.id_pc, e.pc);
            check("xfer_inst", bus.id_inst, e.inst);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.id_ready       = 1'b1;

      step();
      step();
      @(negedge clk);
      check("rst_id_valid", bus.id_valid, 0);
      check("rst_id_pc", bus.id_pc, 0);
      check("rst_id_inst", bus.id_inst, 0);
      check("rst_read_en", bus.rom_read_enable, 0);

      // Release reset; first request goes out immediately.
      step();
      rst_n = 1'b1;
      fill(RESET_PC);
      @(negedge clk);
      check("first_req_en", bus.rom_read_enable, 1);
      check("first_req_addr", bus.rom_address, RESET_PC);
      step();
      @(negedge clk);
      check("lat1_valid", bus.id_valid, 0);
      step();
      @(negedge clk);
      check("lat2_valid", bus.id_valid, 1);
      check("lat2_pc", bus.id_pc, 32'h0);
      check("lat2_inst", bus.id_inst, 32'h0050_0093);

      // Stall for 3 cycles while pc 4 is presented; pc 8 lands in the skid.
      step();
      bus.id_ready = 1'b0;
      @(negedge clk);
      check("stall_pc", bus.id_pc, 32'h4);
      check("stall_read_en", bus.rom_read_enable, 0);
      for (int k = 0; k < 2; k++) begin
         step();
         @(negedge clk);
         check("stall_hold_valid", bus.id_valid, 1);
         check("stall_hold_pc", bus.id_pc, 32'h4);
         check("stall_hold_inst", bus.id_inst, 32'h00A0_0113);
         check("skid_read_en", bus.rom_read_enable, 0);
      end
      step();
      bus.id_ready = 1'b1;
      @(negedge clk);
      check("release_pc", bus.id_pc, 32'h4);
      step();
      @(negedge clk);
      check("drain_pc", bus.id_pc, 32'h8);
      check("drain_inst", bus.id_inst, 32'h0020_81B3);
      for (int k = 0; k < 5; k++) step();
      @(negedge clk);
      check("mid_valid", bus.id_valid, 1);

      // One-cycle reset mid-stream.
      step();
      rst_n = 1'b0;
      fill(RESET_PC);
      @(negedge clk);
      check("midrst_read_en", bus.rom_read_enable, 0);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_valid", bus.id_valid, 0);
      check("midrst_pc", bus.id_pc, 0);
      check("midrst_inst", bus.id_inst, 0);
      step();
      @(negedge clk);
      check("refetch_lat1_valid", bus.id_valid, 0);
      step();
      @(negedge clk);
      check("refetch_valid", bus.id_valid, 1);
      check("refetch_pc", bus.id_pc, RESET_PC);

      // Redirect to 0x40 while pc 8 is in flight.
      step();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h40;
      @(negedge clk);
      check("redir_cur_pc", bus.id_pc, 32'h4);
      check("redir_read_en", bus.rom_read_enable, 0);
      step();
      bus.redirect_valid = 1'b0;
      fill(32'h40);
      @(negedge clk);
      check("redir_n1_valid", bus.id_valid, 0);
      check("redir_req_addr", bus.rom_address, 32'h40);
      step();
      @(negedge clk);
      check("redir_n2_valid", bus.id_valid, 0);
      step();
      @(negedge clk);
      check("redir_tgt_valid", bus.id_valid, 1);
      check("redir_tgt_pc", bus.id_pc, 32'h40);

      // Stall with skid full, then redirect to an unaligned target.
      step();
      bus.id_ready = 1'b0;
      @(negedge clk);
      check("stall2_pc", bus.id_pc, 32'h44);
      step();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h23;
      @(negedge clk);
      check("stall2_hold_pc", bus.id_pc, 32'h44);
      check("stall2_read_en", bus.rom_read_enable, 0);
      step();
      bus.redirect_valid = 1'b0;
      bus.id_ready       = 1'b1;
      fill(32'h23 & ~32'h3);
      @(negedge clk);
      check("stall_redir_valid", bus.id_valid, 0);
      step();
      @(negedge clk);
      check("stall_redir_n2_valid", bus.id_valid, 0);
      step();
      @(negedge clk);
      check("stall_redir_tgt_valid", bus.id_valid, 1);
      check("stall_redir_tgt_pc", bus.id_pc, 32'h20);
      for (int k = 0; k < 3; k++) step();

      // Redirect to the top of the address space; fetch must wrap to 0.
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'hFFFF_FFFC;
      step();
      bus.redirect_valid = 1'b0;
      fill(32'hFFFF_FFFC);
      begin
         bit seen;
         seen = 1'b0;
         for (int k = 0; k < 6 && !seen; k++) begin
            @(negedge clk);
            if (bus.id_valid) seen = 1'b1;
         end
         check("wrap_seen", seen, 1);
         check("wrap_pc", bus.id_pc, 32'hFFFF_FFFC);
      end
      step();
      @(negedge clk);
      check("wrap_next_pc", bus.id_pc, 32'h0);
      for (int k = 0; k < 4; k++) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
